// File: rtl/sbio_pkg.sv
// Shared definitions for the sbio transmitter / monitor pair: state encoding,
// default lane count and a counter-width helper.
package sbio_pkg;

    localparam int SBIO_IO_BITS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } sbio_state_t;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbio_transmitter.sv
// Serialises a parallel payload onto IO_BITS pins: one START_VALUE cycle, then
// PAYLOAD_BITS/IO_BITS data cycles, least-significant chunk first.
module sbio_transmitter
    import sbio_pkg::*;
#(
    parameter int                 IO_BITS      = SBIO_IO_BITS,
    parameter int                 PAYLOAD_BITS = 16,
    parameter logic [IO_BITS-1:0] START_VALUE  = IO_BITS'(1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [IO_BITS-1:0]      pins,
    output logic                    busy,
    output sbio_state_t             fsm_state
);

    localparam int N     = PAYLOAD_BITS / IO_BITS;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (PAYLOAD_BITS == 0 || (PAYLOAD_BITS % IO_BITS) != 0) begin : g_bad_params
        $error("PAYLOAD_BITS must be a nonzero multiple of IO_BITS");
    end

    // Handshake: a payload is taken on any cycle where in_valid && in_ready.
    // in_ready depends only on state and reset, never on in_valid.
    sbio_state_t             state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [PAYLOAD_BITS-1:0] shreg, shreg_nxt;
    logic [IO_BITS-1:0]      pins_nxt;
    logic                    busy_nxt;
    logic                    accept;

    assign fsm_state = state;
    assign in_ready  = !reset && ((state == IDLE) || (state == DATA && cnt == LAST_CNT));
    assign accept    = in_valid && in_ready;

    // pins/busy are registered from the next state, so pins always reflect
    // the current state: START shows START_VALUE, DATA with cnt==k shows chunk k.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        pins_nxt  = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    shreg_nxt = in_data;
                    pins_nxt  = START_VALUE;
                end
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
                pins_nxt  = shreg[IO_BITS-1:0];
                shreg_nxt = shreg >> IO_BITS;
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt = '0;
                    if (accept) begin
                        state_nxt = START;
                        shreg_nxt = in_data;
                        pins_nxt  = START_VALUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    pins_nxt  = shreg[IO_BITS-1:0];
                    shreg_nxt = shreg >> IO_BITS;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            pins  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            pins  <= pins_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sbio_transmitter.sv
// Bench for sbio_transmitter: directed scenarios plus random traffic, checked
// each cycle against a queue holding the pin values still to be transmitted.
module tb_sbio_transmitter;
    import sbio_pkg::*;

    localparam int IO_BITS      = 2;
    localparam int PAYLOAD_BITS = 16;
    localparam int N            = PAYLOAD_BITS / IO_BITS;
    localparam logic [IO_BITS-1:0] START_VALUE = 2'b01;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [PAYLOAD_BITS-1:0] in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [IO_BITS-1:0]      pins;
    logic                    busy;
    sbio_state_t             fsm_state;

    int vectors = 0;
    int miscompares = 0;

    // Front entry is the pin value expected in the current cycle.
    logic [IO_BITS-1:0] exp_q[$];

    sbio_transmitter #(
        .IO_BITS(IO_BITS),
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .START_VALUE(START_VALUE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pins(pins),
        .busy(busy),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs of this cycle, advance model.
    task automatic step(input logic rst, input logic v, input logic [PAYLOAD_BITS-1:0] d);
        logic exp_ready;
        logic acc;
        logic [PAYLOAD_BITS-1:0] p;
        reset    = rst;
        in_valid = v;
        in_data  = d;
        #1;
        exp_ready = !rst && (exp_q.size() <= 1);
        check("pins", 32'(pins), (exp_q.size() == 0) ? 32'd0 : 32'(exp_q[0]));
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) begin
                p = d;
                exp_q.push_back(START_VALUE);
                for (int k = 0; k < N; k++) exp_q.push_back(p[k*IO_BITS +: IO_BITS]);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        // raw reset before the first checked cycle
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step(1'b1, 1'b1, 16'h1234);
        idle_cycles(2);

        // single message, with in_data scrambled while valid is low
        step(1'b0, 1'b1, 16'hA5C3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'(i * 16'h1111));
        idle_cycles(2);

        // back-to-back with valid held: second payload taken on the last chunk
        step(1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0001);
        step(1'b0, 1'b1, 16'hFFFF);
        idle_cycles(11);

        // reset mid-message, then a clean restart
        step(1'b0, 1'b1, 16'hA5C3);
        idle_cycles(3);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 16'h5A3C);
        idle_cycles(11);

        // zero payload is sent as zero chunks
        step(1'b0, 1'b1, 16'h0000);
        idle_cycles(10);

        // random traffic, mostly back-to-back, occasional resets
        for (int i = 0; i < 1200; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) != 0),
                 16'($urandom));
        end
        idle_cycles(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sbio_transmitter.md
SBIO_TRANSMITTER -- requirements
Module: sbio_transmitter

Interface
REQ-001 Parameter IO_BITS, 2, number of parallel serial data lines driven per cycle.
REQ-002 Parameter PAYLOAD_BITS, 16, message payload width; SHALL be a nonzero multiple of IO_BITS.
REQ-003 Parameter START_VALUE, 1 (IO_BITS wide), pin pattern driven during the start cycle; SHALL be nonzero in the bits the receiving sbio_monitor senses.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  PAYLOAD_BITS  payload to transmit; sampled only on acceptance.
REQ-007 in_valid  input  1  payload request.
REQ-008 in_ready  output  1  block can accept a payload this cycle.
REQ-009 pins  output  IO_BITS  serial bus toward a receiver using sbio_monitor; registered.
REQ-010 busy  output  1  high while the start cycle or a data cycle is on pins.

Function
REQ-011 Define N = PAYLOAD_BITS/IO_BITS data cycles per message; message length = 1 start cycle + N data cycles.
REQ-012 States SHALL be IDLE, START, DATA; the data-cycle counter SHALL be $clog2(N) bits wide (min 1).
REQ-013 Acceptance SHALL occur on a cycle with in_valid && in_ready; in_data is latched into a PAYLOAD_BITS shift register.
REQ-014 in_ready SHALL be combinational: 1 in IDLE, 1 in DATA when counter == N-1, else 0; 0 while reset is high.
REQ-015 Acceptance in cycle t SHALL place START_VALUE on pins in cycle t+1 (state START).
REQ-016 Data cycle k (k=0..N-1) SHALL appear on pins in cycle t+2+k, carrying payload bits [k*IO_BITS +: IO_BITS] (LSB chunk first).
REQ-017 START SHALL last exactly one cycle, then go to DATA with counter = 0; counter increments by 1 each DATA cycle.
REQ-018 At DATA with counter == N-1: if a new payload is accepted, next state is START (back-to-back, no idle gap); else next state is IDLE.
REQ-019 In IDLE, pins SHALL be all zeros; busy = 1 exactly in START and DATA.
REQ-020 in_valid deasserted or in_data changing mid-message SHALL have no effect on the message in progress.
REQ-021 A data chunk equal to zero SHALL be driven as zero; the transmitter imposes no encoding beyond the start cycle.
REQ-022 Counter SHALL never exceed N-1; no wrap-around occurs within a message.

Reset
REQ-023 While reset is high at a clock edge: state <= IDLE, counter <= 0, shift register <= 0, pins <= 0, busy <= 0.
REQ-024 Reset asserted mid-message SHALL abort it: pins are zero from the cycle after the reset edge; the aborted payload is never resumed.
REQ-025 No acceptance SHALL occur in a cycle where reset is high.

Structure
REQ-026 The state enum (IDLE/START/DATA) and the default IO_BITS shared with sbio_monitor SHALL live in package sbio_pkg.
REQ-027 The implementation SHALL be a single module with no sub-module; the FSM, counter and shift register are local.
REQ-028 pins and busy SHALL be driven directly from flops (no combinational path from in_valid to pins).

Verification (IO_BITS=2, PAYLOAD_BITS=16, START_VALUE=2'b01, N=8)
REQ-029 Single message 16'hA5C3 accepted at cycle t -> pins: t+1 = 01; t+2..t+9 = 11,00,00,11,01,01,10,10; t+10 = 00; busy high t+1..t+9.
REQ-030 Back-to-back: in_valid held with 16'h0001 then 16'hFFFF -> in_ready high at t and t+9; second start (01) at t+10 directly after the first message's last chunk 00; no idle cycle.
REQ-031 Reset at cycle t+4 of a 16'hA5C3 message -> pins = 00 and busy = 0 from t+5; in_ready = 1 once reset drops; a new message starts cleanly.
REQ-032 in_data changed to 16'h0000 while in_valid is dropped during DATA -> transmitted chunks still match the originally accepted 16'hA5C3.
REQ-033 Loopback with sbio_monitor (SENS_BITS=2, done asserted on its counter == 7) -> monitor start coincides with the 01 cycle, active for 8 cycles, and reassembled payload equals the sent value across 100 random back-to-back payloads.
